// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory path.
//   WORD_W  : data word width
//   BE_W    : byte-enable width (one bit per byte lane)
//   state_e : responder FSM states
package cpu_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Backing word array for the data-memory responder.
// Synchronous byte-masked write, registered read. Contents are never reset.
// Ports:
//   clk_i   : clock
//   we_i    : write strobe; lanes with be_i[k]=1 are updated
//   re_i    : read strobe; loads rdata_o on the next edge, otherwise rdata_o holds
//   idx_i   : word index
//   be_i    : byte enables for writes
//   wdata_i : write data
//   rdata_o : registered read data
module dmem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port. Accepts one request at a time,
// waits LATENCY cycles in BUSY, then presents the response until it is accepted.
// Ports:
//   clk_i, rst_i (async, active-low)
//   req_valid_i/req_ready_o, req_write_i, req_addr_i, req_wdata_i, req_be_i : request channel
//   rsp_valid_o/rsp_ready_i, rsp_rdata_o, rsp_err_o                         : response channel
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [WORD_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;

  logic               req_err;
  logic               mem_we, mem_re;
  logic [WORD_W-1:0]  mem_rdata;

  // Misaligned, or any address bit above the array's byte range is set.
  assign req_err = (|req_addr_i[1:0]) | (|req_addr_i[ADDR_W-1:IDX_W+2]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StBusy;
          cnt_d   = CntInit;
          wr_d    = req_write_i;
          err_d   = req_err;
          idx_d   = req_addr_i[IDX_W+1:2];
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          // Access happens on the edge that leaves BUSY; errors touch nothing.
          mem_we  = wr_q & ~err_q;
          mem_re  = ~wr_q & ~err_q;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .idx_i  (idx_q),
    .be_i   (be_q),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  // Ready is forced low while reset is held, even though the state is already IDLE.
  assign req_ready_o = (state_q == StIdle) & rst_i;
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_rdata_o = (rsp_valid_o && !err_q && !wr_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: DUT a uses LATENCY=2, DUT b uses LATENCY=1 for the streaming case.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;

  logic clk, rst;
  int   cyc;
  int   n_cmp, n_err;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .ADDR_W(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
    .rsp_err_o(a_rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .ADDR_W(32)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
    .rsp_err_o(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_a_ready(input string tag);
    int g = 0;
    while (!a_req_ready && g < 50) begin
      tick();
      g++;
    end
    chk({tag, " ready"}, 32'(a_req_ready), 32'd1);
  endtask

  // One transaction on DUT a; hold = cycles of response backpressure.
  task automatic a_xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err);
    int lat;
    wait_a_ready(tag);
    a_req_valid = 1'b1;
    a_req_write = wr;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    a_rsp_ready = (hold == 0);
    tick();
    // Scramble inputs after the accept edge; they must be ignored.
    a_req_valid = 1'b0;
    a_req_write = ~wr;
    a_req_addr  = 32'h0000_0030;
    a_req_wdata = ~wdata;
    a_req_be    = 4'hF;
    lat = 1;
    while (!a_rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd3);
    rdata = a_rsp_rdata;
    err   = a_rsp_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, " hold valid"}, 32'(a_rsp_valid), 32'd1);
      chk({tag, " hold rdata"}, a_rsp_rdata, rdata);
      chk({tag, " hold err"}, 32'(a_rsp_err), 32'(err));
      chk({tag, " hold req_ready"}, 32'(a_req_ready), 32'd0);
    end
    a_rsp_ready = 1'b1;
    tick();
    chk({tag, " done valid"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, " done idle"}, 32'(a_req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          acc [4];
  logic [31:0] bdat [4];

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0;
    a_rsp_ready = 1;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0;
    b_rsp_ready = 1;
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst req_ready", 32'(a_req_ready), 32'd0);
    chk("rst rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst rdata", a_rsp_rdata, 32'd0);
    chk("rst err", 32'(a_rsp_err), 32'd0);
    rst = 1'b1;
    tick();
    chk("post-rst req_ready", 32'(a_req_ready), 32'd1);

    // Prior content at 0x10, then a store interrupted by reset while BUSY.
    a_xfer("sw10 pre", 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 0, rd, er);
    wait_a_ready("rstbusy");
    a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h10; a_req_wdata = 32'hDEAD_BEEF;
    a_req_be = 4'hF;
    tick();
    a_req_valid = 0;
    rst = 1'b0;
    #1;
    chk("rstbusy valid", 32'(a_rsp_valid), 32'd0);
    chk("rstbusy ready low", 32'(a_req_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rstbusy ready", 32'(a_req_ready), 32'd1);
    chk("rstbusy valid after", 32'(a_rsp_valid), 32'd0);
    a_xfer("lw10", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("lw10 rdata", rd, 32'h0BAD_F00D);

    // Full-word store and load.
    a_xfer("sw20", 1'b1, 32'h20, 32'h1234_5678, 4'hF, 0, rd, er);
    chk("sw20 err", 32'(er), 32'd0);
    chk("sw20 rdata", rd, 32'd0);
    a_xfer("lw20", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("lw20 rdata", rd, 32'h1234_5678);
    chk("lw20 err", 32'(er), 32'd0);

    // Byte enables, including an all-zero no-op store.
    a_xfer("sw24 pre", 1'b1, 32'h24, 32'hAABB_CCDD, 4'hF, 0, rd, er);
    a_xfer("sw24 be", 1'b1, 32'h24, 32'h1122_3344, 4'b0101, 0, rd, er);
    a_xfer("lw24", 1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er);
    chk("lw24 rdata", rd, 32'hAA22_CC44);
    a_xfer("sw24 be0", 1'b1, 32'h24, 32'h0, 4'b0000, 0, rd, er);
    chk("sw24 be0 err", 32'(er), 32'd0);
    a_xfer("lw24b", 1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er);
    chk("lw24b rdata", rd, 32'hAA22_CC44);

    // Backpressure for 5 cycles.
    a_xfer("lw20 bp", 1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er);
    chk("lw20 bp rdata", rd, 32'h1234_5678);

    // Errors: misaligned load, out-of-range and misaligned stores.
    a_xfer("sw0 pre", 1'b1, 32'h0, 32'h0102_0304, 4'hF, 0, rd, er);
    a_xfer("lw2", 1'b0, 32'h2, 32'h0, 4'h0, 0, rd, er);
    chk("lw2 err", 32'(er), 32'd1);
    chk("lw2 rdata", rd, 32'd0);
    a_xfer("sw oor", 1'b1, 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    chk("sw oor err", 32'(er), 32'd1);
    a_xfer("sw22", 1'b1, 32'h22, 32'hFFFF_FFFF, 4'hF, 0, rd, er);
    chk("sw22 err", 32'(er), 32'd1);
    a_xfer("lw0", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er);
    chk("lw0 unchanged", rd, 32'h0102_0304);
    a_xfer("lw20c", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("lw20 unchanged", rd, 32'h1234_5678);

    // LATENCY=1 stream on DUT b: preload four words, then back-to-back loads.
    for (int k = 0; k < 4; k++) begin
      int g = 0;
      while (!b_req_ready && g < 50) begin tick(); g++; end
      b_req_valid = 1; b_req_write = 1; b_req_addr = 32'h40 + 32'(4 * k);
      b_req_wdata = 32'hC0DE_0000 + 32'(k); b_req_be = 4'hF;
      tick();
      b_req_valid = 0;
      g = 0;
      while (!b_rsp_valid && g < 50) begin tick(); g++; end
      chk("b sw valid", 32'(b_rsp_valid), 32'd1);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      int g = 0;
      while (!b_req_ready && g < 50) begin tick(); g++; end
      b_req_valid = 1; b_req_write = 0; b_req_addr = 32'h40 + 32'(4 * k);
      tick();
      acc[k] = cyc;
      b_req_valid = 0;
      g = 0;
      while (!b_rsp_valid && g < 50) begin tick(); g++; end
      chk("b lw valid", 32'(b_rsp_valid), 32'd1);
      chk("b lw err", 32'(b_rsp_err), 32'd0);
      bdat[k] = b_rsp_rdata;
    end
    for (int k = 0; k < 4; k++) begin
      chk("b stream data", bdat[k], 32'hC0DE_0000 + 32'(k));
      if (k > 0) chk("b stream spacing", 32'(acc[k] - acc[k-1]), 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
